// File: rtl/jedro_1_dmem_responder_if.sv
// jedro_1 data-memory port: LSU (master) to data memory (slave).
// Signal names match the responder's port list so both ends read the same.
interface jedro_1_dmem_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_i;
    logic                  we_i;
    logic [3:0]            be_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [31:0]           wdata_i;
    logic                  gnt_o;
    logic                  rvalid_o;
    logic [31:0]           rdata_o;
    logic                  err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/jedro_1_dmem_responder.sv
// jedro_1 data-memory responder: one request at a time, byte-enabled writes,
// fixed-latency reads from a word-organised RAM, one-cycle response pulse.
// Optional feature macro: JEDRO_1_DMEM_STATS_EN adds rd_cnt_o / wr_cnt_o
// counters of in-range reads and writes.
module jedro_1_dmem_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    jedro_1_dmem_responder_if.slave bus
`ifdef JEDRO_1_DMEM_STATS_EN
    ,
    output logic [31:0]            rd_cnt_o,
    output logic [31:0]            wr_cnt_o
`endif
);
    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WAIT_LOAD = 3'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RESP    = 2'd2;

    logic [1:0]            state;
    logic [2:0]            cnt;
    logic [DATA_WIDTH-1:0] ram [DEPTH_WORDS];

    logic                  accept;
    logic [IDX_W-1:0]      idx_in;
    logic                  oor_in;
    logic [IDX_W-1:0]      idx_q;
    logic                  oor_q;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_oor;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  unused_addr_lsbs;

    // Byte offset within the word plays no part in word addressing.
    assign unused_addr_lsbs = ^bus.addr_i[1:0];

    // Decode the incoming request; in IDLE the RAM is addressed straight from
    // the bus so a latency-1 read completes at the accept edge, otherwise from
    // the captured request.
    always_comb begin
        bus.gnt_o = rstn_i && (state == IDLE);
        accept    = bus.req_i && bus.gnt_o;
        idx_in    = bus.addr_i[IDX_W+1:2];
        oor_in    = (bus.addr_i >> (IDX_W + 2)) != '0;
        rd_idx    = (state == IDLE) ? idx_in : idx_q;
        rd_oor    = (state == IDLE) ? oor_in : oor_q;
        wr_fire   = accept && bus.we_i;
        rd_fire   = ((READ_LATENCY == 1) && accept && !bus.we_i) ||
                    ((state == RD_WAIT) && (cnt == 3'd0));
    end

    // Control FSM: writes and latency-1 reads go straight to RESP, longer
    // reads count down in RD_WAIT first.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.we_i || (READ_LATENCY == 1)) begin
                            state <= RESP;
                        end else begin
                            state <= RD_WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == 3'd0) state <= RESP;
                    else             cnt   <= cnt - 3'd1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Hold the read address for reads that wait in RD_WAIT.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            idx_q <= idx_in;
            oor_q <= oor_in;
        end
    end

    // Byte-lane writes commit at the accept edge; out-of-range writes are dropped.
    always_ff @(posedge clk_i) begin
        if (wr_fire && !oor_in) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.be_i[k]) ram[idx_in][8*k +: 8] <= bus.wdata_i[8*k +: 8];
            end
        end
    end

    // Registered response: one-cycle pulse with data/error, zero otherwise.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            bus.rvalid_o <= 1'b0;
            bus.rdata_o  <= '0;
            bus.err_o    <= 1'b0;
        end else begin
            bus.rvalid_o <= rd_fire || wr_fire;
            bus.err_o    <= (rd_fire || wr_fire) && rd_oor;
            bus.rdata_o  <= (rd_fire && !rd_oor) ? ram[rd_idx] : '0;
        end
    end

`ifdef JEDRO_1_DMEM_STATS_EN
    // Count accepted in-range reads and writes; wraps naturally at 2^32.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else if (accept && !oor_in) begin
            if (bus.we_i) wr_cnt_o <= wr_cnt_o + 32'd1;
            else          rd_cnt_o <= rd_cnt_o + 32'd1;
        end
    end
`endif
endmodule
